// File: rtl/x7seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// X7SEG_LZ_BLANK_EN (when defined) enables leading-zero suppression in x7seg_scan_ctrl.
package x7seg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low glyphs, bit 6 = segment a ... bit 0 = segment g; entry 0 is rightmost.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Index of the most significant nonzero nibble; 0 when the whole value is zero.
  function automatic logic [1:0] msd_index(input logic [15:0] v);
    logic [1:0] idx;
    if (v[15:12] != 4'h0) begin
      idx = 2'd3;
    end else if (v[11:8] != 4'h0) begin
      idx = 2'd2;
    end else if (v[7:4] != 4'h0) begin
      idx = 2'd1;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/x7seg_hex_decode.sv
// Combinational nibble to active-low seven-segment lookup.
module x7seg_hex_decode
  import x7seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/x7seg_scan_ctrl.sv
// Four-digit common-anode scan controller with blanking gaps and a frame-synchronous update handshake.
// Build option: define X7SEG_LZ_BLANK_EN to suppress leading zeros (digit 0 always shown).
module x7seg_scan_ctrl
  import x7seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [6:0]  a_to_g,
  output logic        dp,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_s;

  logic [15:0]      disp_q, disp_d, shadow_q, shadow_d;
  logic [3:0]       dpr_q, dpr_d, shdp_q, shdp_d;
  logic             pending_q, pending_d;
  logic             xfer_s, commit_s;

  logic [3:0]       nib_s;
  logic [6:0]       seg_dec_s;
  logic             lz_blank_s, lit_s;

  logic [3:0]       an_q, an_d, digit_q, digit_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d, frame_done_q;

  // Scan sequencing: dwell counter runs 0..N-1 in each state and clears on every transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    wrap_s  = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          wrap_s  = (idx_q == 2'd3);
        end else begin
          state_d = BLANK;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          state_d = SHOW;
        end
      end
      default: begin
        state_d = BLANK;
        idx_d   = 2'd3;
        cnt_d   = '0;
      end
    endcase
  end

  // The shadow holds at most one update; it is committed only at the frame boundary so a frame is never torn.
  always_comb begin
    xfer_s   = data_valid & ~pending_q;
    commit_s = wrap_s & pending_q;
    shadow_d = shadow_q;
    shdp_d   = shdp_q;
    disp_d   = disp_q;
    dpr_d    = dpr_q;
    if (xfer_s) begin
      shadow_d  = data_in;
      shdp_d    = dp_in;
    end else begin
      shadow_d  = shadow_q;
    end
    if (commit_s) begin
      disp_d = shadow_q;
      dpr_d  = shdp_q;
    end else begin
      disp_d = disp_q;
    end
    if (xfer_s) begin
      pending_d = 1'b1;
    end else if (commit_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Outputs are built from next-state values so registered pins change together with the state.
  always_comb begin
    case (idx_d)
      2'd0:    nib_s = disp_d[3:0];
      2'd1:    nib_s = disp_d[7:4];
      2'd2:    nib_s = disp_d[11:8];
      2'd3:    nib_s = disp_d[15:12];
      default: nib_s = 4'h0;
    endcase
`ifdef X7SEG_LZ_BLANK_EN
    lz_blank_s = (idx_d > msd_index(disp_d));
`else
    lz_blank_s = 1'b0;
`endif
    lit_s = (state_d == SHOW) & ~lz_blank_s;
    if (lit_s) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = seg_dec_s;
      dp_d  = ~dpr_d[idx_d];
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
    if (state_d == SHOW) begin
      digit_d = nib_s;
    end else begin
      digit_d = digit_q;
    end
  end

  x7seg_hex_decode u_dec (
    .nibble_i (nib_s),
    .seg_o    (seg_dec_s)
  );

  // State, handshake and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      idx_q        <= 2'd3;
      cnt_q        <= '0;
      disp_q       <= 16'h0000;
      dpr_q        <= 4'b0000;
      shadow_q     <= 16'h0000;
      shdp_q       <= 4'b0000;
      pending_q    <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      digit_q      <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      dpr_q        <= dpr_d;
      shadow_q     <= shadow_d;
      shdp_q       <= shdp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_q      <= digit_d;
      frame_done_q <= wrap_s;
    end
  end

  assign data_ready = ~pending_q;
  assign a_to_g     = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit      = digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/x7seg_scan_ctrl.md
Name: x7seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Holds a 16-bit hex value plus 4 decimal points.
- Strobes one digit at a time, with a blanking gap between digits to suppress ghosting.
- Feeds each nibble through a hex-to-segment decoder.
- Sits between system logic, which posts values through a valid/ready handshake, and the board display pins.

Parameters:
- REFRESH_DIV, 100000: cycles each digit is lit (1 ms at 100 MHz); must be ≥2.
- BLANK_CYCLES, 1000: cycles all anodes are off between digits; must be ≥1.
- CNT_W, 17: width of the shared dwell counter; must hold max(REFRESH_DIV, BLANK_CYCLES)-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  16  value to display; nibble k drives digit k (digit 0 rightmost).
- dp_in  in  4  decimal points; bit k for digit k, 1 = lit.
- data_valid  in  1  requester offers data_in/dp_in this cycle.
- data_ready  out  1  high when no update is pending; a transfer occurs when valid && ready.
- a_to_g  out  7  segments a..g, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  4  digit anodes, active-low, one-hot-low or all high, registered.
- digit  out  4  nibble currently being shown (debug/observe), registered.
- frame_done  out  1  one-cycle pulse when a full 4-digit scan completes.

Behaviour:
- Reset values (all outputs registered, synchronous, active-high reset):
  - an=4'b1111, a_to_g=7'b1111111, dp=1, digit=0, frame_done=0, data_ready=1.
  - Display register = 16'h0000, dp register = 4'b0000, pending=0.
  - State = BLANK, digit index = 3, dwell counter = 0.
- FSM states:
  - BLANK: an=4'b1111, segments off.
  - SHOW: an[idx]=0, a_to_g = decode(display[idx]), dp = ~dp_reg[idx].
- Transitions (counter counts 0..N-1 and clears on each transition):
  - BLANK → SHOW when counter == BLANK_CYCLES-1; idx advances mod 4.
  - SHOW → BLANK when counter == REFRESH_DIV-1.
- Each state holds its outputs for exactly its dwell count in clock cycles.
- Frame boundary is the BLANK→SHOW transition where idx wraps 3→0. On that edge:
  - if pending, display/dp registers load from the shadow, pending clears;
  - frame_done pulses for the same one cycle in which the new idx=0 outputs first appear.
- Handshake:
  - On valid && ready, data_in/dp_in are captured into the shadow register and pending is set.
  - data_ready = ~pending, so a value is never torn mid-frame.
  - If a transfer and a frame-boundary commit fall in the same cycle, the commit uses the old shadow and the new transfer stays pending for the next frame.
- First digit: after rst falls, digit 0 lights BLANK_CYCLES cycles after the first non-reset edge, because reset starts in BLANK with idx=3.
- Reset mid-scan: returns to the reset state on the next edge.
  - The display register returns to 0.
  - Any pending update is discarded.
- Decoder: standard hex glyphs 0–F; 'b' and 'd' are lowercase.

Optional Feature:
Macro: X7SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - Digits above the most significant nonzero nibble are blanked: an stays 1, segments and dp off.
  - The timing slot is still consumed, so frame period is unchanged.
  - Digit 0 is always shown.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package x7seg_pkg:
  - state enum {BLANK, SHOW};
  - SEG_OFF = 7'b1111111, AN_OFF = 4'b1111;
  - the 16-entry hex glyph constant table.
- Sub-module x7seg_hex_decode: combinational nibble → a_to_g lookup, instantiated once and fed by the muxed nibble.
- Scan FSM, counter and handshake stay in the top.

Test Plan:
All scenarios use REFRESH_DIV=4, BLANK_CYCLES=2.
1. Reset, then hold valid=0 → an=1111 for 2 cycles, then an=1110 with a_to_g=7'b0000001 ('0') for 4 cycles, then 1111 ×2, then 1101, and so on; frame_done pulses every 24 cycles.
2. Post data_in=16'h12AF, dp_in=4'b0100 mid-frame → data_ready drops; display is unchanged until the wrap. Next frame shows:
   - digit0 'F' (7'b0111000);
   - digit1 'A' (7'b0001000);
   - digit2 '2' (7'b0010010) with dp=0;
   - digit3 '1' (7'b1001111).
   data_ready returns to 1 at the frame_done cycle.
3. Hold valid=1 with data changing every cycle → exactly one transfer per frame; each committed value equals data_in at the cycle ready was high.
4. Assert valid in the cycle the commit occurs → the old shadow displays and the new value shows one frame later.
5. Assert rst for 1 cycle while digit 2 is lit → next edge gives an=1111 and digit=0; after 2 cycles digit 0 shows '0'.
6. With X7SEG_LZ_BLANK_EN, data=16'h0030 → an never goes low in the digit 2 or 3 slots; digit1 shows '3', digit0 shows '0'; frame period stays 24 cycles.
